// File: rtl/prio_irq_if.sv
// Handshake bundle between peripheral request lines / CPU interrupt port and prio_irq_ctrl.
// master = request and consumer side, slave = the controller.
interface prio_irq_if #(
    parameter int NUM_CH  = 9,
    parameter int NUM_GRP = 3
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int GRP_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

    logic [NUM_GRP*NUM_CH-1:0] req_i;
    logic [NUM_CH-1:0]         ch_en_i;
    logic                      ack_i;
    logic                      irq_valid_o;
    logic [GRP_W-1:0]          irq_grp_o;
    logic [CH_W-1:0]           irq_ch_o;
    logic [NUM_GRP-1:0]        grp_pend_o;
    logic                      any_pend_o;

    modport master (
        output req_i, ch_en_i, ack_i,
        input  irq_valid_o, irq_grp_o, irq_ch_o, grp_pend_o, any_pend_o
    );

    modport slave (
        input  req_i, ch_en_i, ack_i,
        output irq_valid_o, irq_grp_o, irq_ch_o, grp_pend_o, any_pend_o
    );
endinterface

// File: rtl/prio_irq_ctrl.sv
// Registered interrupt priority controller: sticky edge-captured pending bits, per-channel
// enable, fixed group priority. Define PRIO_IRQ_RR_EN for round-robin order within a group.
module prio_irq_ctrl #(
    parameter int NUM_CH  = 9,
    parameter int NUM_GRP = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    prio_irq_if.slave  bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int GRP_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int TOT   = NUM_GRP * NUM_CH;

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    state_t              state_r;
    logic                valid_r;
    logic [GRP_W-1:0]    grp_r;
    logic [CH_W-1:0]     ch_r;
    logic [TOT-1:0]      req_q_r;
    logic [TOT-1:0]      pend_r;
    logic [TOT-1:0]      elig_s;
    logic [TOT-1:0]      set_s;
    logic [TOT-1:0]      clr_s;
    logic [TOT-1:0]      pend_nxt_s;
    logic [NUM_GRP-1:0]  grp_pend_s;
    logic                any_pend_s;
    logic                ack_hit_s;
    logic [CH_W-1:0]     grp_ch_s [NUM_GRP];
    logic [GRP_W-1:0]    win_grp_s;
    logic [CH_W-1:0]     win_ch_s;

    assign ack_hit_s = (state_r == PRESENT) && bus.ack_i;
    assign set_s     = bus.req_i & ~req_q_r;

    // Eligibility and per-group pending summary
    always_comb begin
        elig_s = pend_r & {NUM_GRP{bus.ch_en_i}};
        for (int g = 0; g < NUM_GRP; g++) begin
            grp_pend_s[g] = |elig_s[g*NUM_CH +: NUM_CH];
        end
        any_pend_s = |grp_pend_s;
    end

    // Pending next state: a new edge on the acked channel beats the clear
    always_comb begin
        for (int g = 0; g < NUM_GRP; g++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                clr_s[g*NUM_CH+c] = ack_hit_s && (grp_r == GRP_W'(g)) && (ch_r == CH_W'(c));
            end
        end
        pend_nxt_s = (pend_r & ~clr_s) | set_s;
    end

`ifdef PRIO_IRQ_RR_EN
    logic [CH_W-1:0] rr_r [NUM_GRP];

    // Per-group winner: smallest rotated distance from the group's pointer
    always_comb begin
        int  best;
        int  dist;
        logic hit;
        for (int g = 0; g < NUM_GRP; g++) begin
            grp_ch_s[g] = '0;
            best        = NUM_CH;
            for (int c = 0; c < NUM_CH; c++) begin
                dist        = (c + NUM_CH - int'(rr_r[g])) % NUM_CH;
                hit         = elig_s[g*NUM_CH+c] && (dist < best);
                grp_ch_s[g] = hit ? CH_W'(c) : grp_ch_s[g];
                best        = hit ? dist : best;
            end
        end
    end

    // Round-robin pointers advance past the acknowledged channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                rr_r[g] <= '0;
            end
        end else if (ack_hit_s) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                if (grp_r == GRP_W'(g)) begin
                    rr_r[g] <= (ch_r == CH_W'(NUM_CH - 1)) ? '0 : ch_r + CH_W'(1);
                end
            end
        end
    end
`else
    // Per-group winner: lowest eligible channel index
    always_comb begin
        for (int g = 0; g < NUM_GRP; g++) begin
            grp_ch_s[g] = '0;
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                grp_ch_s[g] = elig_s[g*NUM_CH+c] ? CH_W'(c) : grp_ch_s[g];
            end
        end
    end
`endif

    // Lowest pending group wins, then take that group's channel
    always_comb begin
        win_grp_s = '0;
        for (int g = NUM_GRP - 1; g >= 0; g--) begin
            win_grp_s = grp_pend_s[g] ? GRP_W'(g) : win_grp_s;
        end
        win_ch_s = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            win_ch_s = (win_grp_s == GRP_W'(g)) ? grp_ch_s[g] : win_ch_s;
        end
    end

    // Request edge capture and sticky pending bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q_r <= '0;
            pend_r  <= '0;
        end else begin
            req_q_r <= bus.req_i;
            pend_r  <= pend_nxt_s;
        end
    end

    // Presentation FSM; winner is frozen while PRESENT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            grp_r   <= '0;
            ch_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_pend_s) begin
                        grp_r   <= win_grp_s;
                        ch_r    <= win_ch_s;
                        valid_r <= 1'b1;
                        state_r <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.ack_i) begin
                        valid_r <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq_valid_o = valid_r;
    assign bus.irq_grp_o   = grp_r;
    assign bus.irq_ch_o    = ch_r;
    assign bus.grp_pend_o  = grp_pend_s;
    assign bus.any_pend_o  = any_pend_s;
endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Scoreboard bench for prio_irq_ctrl: directed stimulus pushes expected (group, channel)
// pairs; a monitor pops one on every new irq_valid_o presentation.
module tb_prio_irq_ctrl;
    localparam int NUM_CH  = 9;
    localparam int NUM_GRP = 3;

    logic clk;
    logic rst_n;
    int   vectors;
    int   fails;
    logic prev_v;
    logic [15:0] exp_q [$];

    prio_irq_if #(.NUM_CH(NUM_CH), .NUM_GRP(NUM_GRP)) bus ();

    prio_irq_ctrl #(.NUM_CH(NUM_CH), .NUM_GRP(NUM_GRP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_irq(input int g, input int c);
        exp_q.push_back({8'(g), 8'(c)});
    endtask

    task automatic pulse(input int idx);
        bus.req_i[idx] = 1'b1;
        @(negedge clk);
        bus.req_i[idx] = 1'b0;
    endtask

    task automatic ack_once();
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!bus.irq_valid_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", 32'(bus.irq_valid_o), 32'd1);
    endtask

    // Monitor: compare each new presentation against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && bus.irq_valid_o && !prev_v) begin
            vectors++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_irq: got g%0d c%0d expected none", bus.irq_grp_o, bus.irq_ch_o);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({8'(bus.irq_grp_o), 8'(bus.irq_ch_o)} !== e) begin
                    fails++;
                    $display("FAIL irq_winner: got g%0d c%0d expected g%0d c%0d",
                             bus.irq_grp_o, bus.irq_ch_o, e[15:8], e[7:0]);
                end
            end
        end
        prev_v <= bus.irq_valid_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        fails       = 0;
        prev_v      = 1'b0;
        rst_n       = 1'b0;
        bus.req_i   = '0;
        bus.ch_en_i = 9'h1FF;
        bus.ack_i   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.irq_valid_o), 32'd0);
        chk("rst_grp", 32'(bus.irq_grp_o), 32'd0);
        chk("rst_ch", 32'(bus.irq_ch_o), 32'd0);
        chk("rst_any_pend", 32'(bus.any_pend_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: edge k pends, valid after k+1
        expect_irq(1, 4);
        pulse(13);
        chk("lat_valid_k", 32'(bus.irq_valid_o), 32'd0);
        chk("lat_grp_pend", 32'(bus.grp_pend_o), 32'b010);
        chk("lat_any_pend", 32'(bus.any_pend_o), 32'd1);
        @(negedge clk);
        chk("lat_valid_k1", 32'(bus.irq_valid_o), 32'd1);
        ack_once();
        chk("ack_drop", 32'(bus.irq_valid_o), 32'd0);

        // Priority: three groups at once, two-cycle spacing
        bus.req_i[20] = 1'b1;
        bus.req_i[10] = 1'b1;
        bus.req_i[5]  = 1'b1;
        expect_irq(0, 5);
        expect_irq(1, 1);
        expect_irq(2, 2);
        @(negedge clk);
        bus.req_i = '0;
        @(negedge clk);
        chk("prio_first", 32'(bus.irq_valid_o), 32'd1);
        for (int i = 0; i < 2; i++) begin
            ack_once();
            chk("prio_gap", 32'(bus.irq_valid_o), 32'd0);
            @(negedge clk);
            chk("prio_next", 32'(bus.irq_valid_o), 32'd1);
        end
        ack_once();

        // Mask: retained while disabled, presented once enabled
        bus.ch_en_i = 9'h1F7;
        pulse(3);
        repeat (2) @(negedge clk);
        chk("mask_valid", 32'(bus.irq_valid_o), 32'd0);
        chk("mask_any_pend", 32'(bus.any_pend_o), 32'd0);
        chk("mask_grp_pend", 32'(bus.grp_pend_o), 32'd0);
        expect_irq(0, 3);
        bus.ch_en_i = 9'h1FF;
        @(negedge clk);
        chk("mask_release", 32'(bus.irq_valid_o), 32'd1);
        ack_once();

        // Hold: a higher-priority edge does not retract the winner
        expect_irq(2, 8);
        pulse(26);
        wait_valid(4);
        expect_irq(0, 0);
        pulse(0);
        for (int i = 0; i < 10; i++) begin
            chk("hold_outputs", {8'(bus.irq_valid_o), 8'(bus.irq_grp_o), 8'(bus.irq_ch_o)},
                32'h01_02_08);
            @(negedge clk);
        end
        ack_once();
        @(negedge clk);
        chk("hold_next", 32'(bus.irq_valid_o), 32'd1);
        ack_once();

        // Set-over-clear on the acked channel
        expect_irq(1, 4);
        pulse(13);
        wait_valid(4);
        expect_irq(1, 4);
        bus.ack_i     = 1'b1;
        bus.req_i[13] = 1'b1;
        @(negedge clk);
        bus.ack_i     = 1'b0;
        bus.req_i[13] = 1'b0;
        chk("soc_gap", 32'(bus.irq_valid_o), 32'd0);
        @(negedge clk);
        chk("soc_repend", 32'(bus.irq_valid_o), 32'd1);
        ack_once();

        // Level-held request does not re-pend after ack
        expect_irq(0, 7);
        bus.req_i[7] = 1'b1;
        @(negedge clk);
        wait_valid(4);
        ack_once();
        repeat (3) begin
            @(negedge clk);
            chk("level_no_repend", {31'(bus.irq_valid_o), bus.any_pend_o}, 32'd0);
        end
        bus.req_i[7] = 1'b0;
        @(negedge clk);

        // Asynchronous reset while PRESENT
        expect_irq(0, 1);
        pulse(1);
        wait_valid(4);
        pulse(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_valid", 32'(bus.irq_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("async_no_stale", {bus.grp_pend_o, bus.any_pend_o, bus.irq_valid_o}, 32'd0);
        end

`ifdef PRIO_IRQ_RR_EN
        // Round-robin inside group 0: channels 2 and 5 alternate
        bus.req_i[2] = 1'b1;
        bus.req_i[5] = 1'b1;
        expect_irq(0, 2);
        @(negedge clk);
        bus.req_i = '0;
        wait_valid(4);
        for (int i = 0; i < 3; i++) begin
            int cur;
            cur = (i % 2 == 0) ? 2 : 5;
            expect_irq(0, (i % 2 == 0) ? 5 : 2);
            bus.ack_i      = 1'b1;
            bus.req_i[cur] = 1'b1;
            @(negedge clk);
            bus.ack_i      = 1'b0;
            bus.req_i[cur] = 1'b0;
            @(negedge clk);
            chk("rr_next", 32'(bus.irq_valid_o), 32'd1);
        end
        ack_once();
        @(negedge clk);
        ack_once();
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
